// File: rtl/prand_pkg.sv
// prand_pkg: shared types and constants for the random-number scheduler.
//   PRAND_W            - width of the LFSR generator value and seed
//   PRAND_DEFAULT_SEED - seed loaded into the generator after reset
//   prand_state_t      - scheduler state encoding
package prand_pkg;

  localparam int PRAND_W = 64;

  localparam logic [PRAND_W-1:0] PRAND_DEFAULT_SEED = 64'h0123456789ABCDEF;

  typedef enum logic [2:0] {
    LOAD,
    WARM,
    IDLE,
    STEP,
    DELIVER
  } prand_state_t;

endpackage

// File: rtl/prand_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req       - request vector
//   mask      - requesters excluded from this round (just acknowledged)
//   rr_ptr    - index where the search starts
//   grant     - one-hot grant (all zero when nothing is eligible)
//   grant_idx - index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0]   pos;
  logic               found;

  always_comb begin
    eligible  = req & ~mask;
    grant     = '0;
    grant_idx = '0;
    pos       = '0;
    found     = 1'b0;
    // Walk the ring once starting at rr_ptr; the first eligible wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && eligible[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/prand_sched.sv
// prand_sched: shares one 64-bit LFSR generator among NUM_REQ consumers.
// Owns the generator's seed load / run controls, warms the generator up after
// every (re)seed and serves draw requests round-robin; each draw advances the
// generator STEPS_PER_DRAW times before the value is delivered.
//   clk, nReset          - clock, asynchronous active-low reset
//   reseed, seed_in      - one-cycle reseed pulse with the new seed
//   req / ack            - level requests / one-hot one-cycle acknowledge
//   rnd_data             - delivered value, valid with ack, held otherwise
//   ready, busy          - generator warmed up / state is not IDLE
//   prng_load, prng_run  - generator seed-load and advance controls
//   prng_seed            - registered seed presented to the generator
//   prng_value           - current generator output
module prand_sched
  import prand_pkg::*;
#(
  parameter int                 NUM_REQ        = 4,
  parameter int                 STEPS_PER_DRAW = 8,
  parameter int                 WARMUP_STEPS   = 64,
  parameter logic [PRAND_W-1:0] DEFAULT_SEED   = PRAND_DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               reseed,
  input  logic [PRAND_W-1:0] seed_in,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [PRAND_W-1:0] rnd_data,
  output logic               ready,
  output logic               busy,
  output logic               prng_load,
  output logic               prng_run,
  output logic [PRAND_W-1:0] prng_seed,
  input  logic [PRAND_W-1:0] prng_value
);

  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_STEPS = (WARMUP_STEPS > STEPS_PER_DRAW) ? WARMUP_STEPS : STEPS_PER_DRAW;
  localparam int CNT_W     = $clog2(MAX_STEPS + 1);

  localparam logic [CNT_W-1:0] WARM_COUNT = CNT_W'(WARMUP_STEPS);
  localparam logic [CNT_W-1:0] STEP_COUNT = CNT_W'(STEPS_PER_DRAW);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
    $error("prand_sched: NUM_REQ must be in 1..8");
  end
  if (STEPS_PER_DRAW < 1) begin : g_bad_steps
    $error("prand_sched: STEPS_PER_DRAW must be at least 1");
  end
  if (WARMUP_STEPS < 1) begin : g_bad_warmup
    $error("prand_sched: WARMUP_STEPS must be at least 1");
  end

  prand_state_t       state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   id;
  logic               reseed_pend;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_take;
  logic [IDX_W-1:0]   ptr_after;

  // The requester acked this cycle may still hold req; mask it so a
  // continuously requesting consumer cannot be served twice in a row.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req),
    .mask      (ack),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A pending or arriving reseed wins over any request in IDLE.
  assign grant_take = (state == IDLE) && !(reseed || reseed_pend) && (|grant);
  assign ptr_after  = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      LOAD: begin
        state_nxt = WARM;
        cnt_nxt   = WARM_COUNT;
      end
      WARM: begin
        if (cnt == CNT_ONE) state_nxt = IDLE;
        else                cnt_nxt   = cnt - CNT_ONE;
      end
      IDLE: begin
        if (reseed || reseed_pend) begin
          state_nxt = LOAD;
        end else if (|grant) begin
          state_nxt = STEP;
          cnt_nxt   = STEP_COUNT;
        end
      end
      STEP: begin
        if (cnt == CNT_ONE) state_nxt = DELIVER;
        else                cnt_nxt   = cnt - CNT_ONE;
      end
      DELIVER: state_nxt = IDLE;
      default: state_nxt = LOAD;
    endcase
    // Reseeding during seed load or warm-up restarts the whole sequence.
    if (reseed && (state == LOAD || state == WARM)) state_nxt = LOAD;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state       <= LOAD;
      cnt         <= '0;
      rr_ptr      <= '0;
      id          <= '0;
      reseed_pend <= 1'b0;
      prng_seed   <= DEFAULT_SEED;
      rnd_data    <= '0;
      ack         <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (reseed) prng_seed <= seed_in;
      // Pending flag is consumed by the transition into LOAD.
      reseed_pend <= (state_nxt == LOAD) ? 1'b0 : (reseed_pend | reseed);
      if (grant_take) begin
        id     <= grant_idx;
        rr_ptr <= ptr_after;
      end
      ack <= '0;
      if (state == DELIVER) begin
        ack[id]  <= 1'b1;
        rnd_data <= prng_value;
      end
    end
  end

  assign prng_load = (state == LOAD);
  assign prng_run  = (state == WARM) || (state == STEP);
  assign ready     = (state == IDLE) || (state == STEP) || (state == DELIVER);
  assign busy      = (state != IDLE);

endmodule

// File: doc/prand_sched.md
# prand_sched

Scheduler that shares the single 64-bit LFSR generator among up to `NUM_REQ` consumers in the LED-matrix design. It owns the generator's seed-load and run controls, runs a warm-up after every (re)seed, and arbitrates draw requests round-robin. Each served request gets a 64-bit value after the generator has advanced `STEPS_PER_DRAW` times.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, legal range 1..8.
- `STEPS_PER_DRAW`, default 8: generator advances per draw, at least 1.
- `WARMUP_STEPS`, default 64: generator advances after every seed load, at least 1.
- `DEFAULT_SEED`, default 64'h0123456789ABCDEF: seed loaded after reset.

Ports:
- `clk` in 1: the single clock.
- `nReset` in 1: asynchronous, active-low reset.
- `reseed` in 1: one-cycle pulse requesting a new seed.
- `seed_in` in 64: the seed, captured in the same cycle as `reseed`.
- `req` in `NUM_REQ`: level draw requests, held until acknowledged.
- `ack` out `NUM_REQ`: one-hot, one-cycle pulse; `rnd_data` is valid in that cycle.
- `rnd_data` out 64: delivered value, held between acks.
- `ready` out 1: generator seeded and warmed up.
- `busy` out 1: high whenever state is not IDLE.
- `prng_load` out 1: drives the generator's synchronous seed load.
- `prng_run` out 1: generator advance enable.
- `prng_seed` out 64: registered seed presented to the generator.
- `prng_value` in 64: current generator output.

## Operation
- States: LOAD, WARM, IDLE, STEP, DELIVER.
- LOAD (1 cycle):
  - `prng_load`=1, `prng_run`=0.
  - Next state: WARM, with the step counter set to `WARMUP_STEPS`.
- WARM:
  - `prng_run`=1 for exactly `WARMUP_STEPS` consecutive cycles.
  - Then go to IDLE.
- IDLE, arbitration:
  - Round-robin search starts at `rr_ptr`.
  - The requester whose `ack` is high this cycle is masked.
  - On a grant: latch the index, set `rr_ptr` = index+1 mod `NUM_REQ`, go to STEP.
- STEP:
  - `prng_run`=1 for exactly `STEPS_PER_DRAW` cycles.
  - Then go to DELIVER.
- DELIVER (1 cycle):
  - `prng_run`=0.
  - Register `rnd_data` <= `prng_value` and set `ack[id]`.
  - Go to IDLE. `ack` is therefore visible during the first IDLE cycle.
- `ready`=1 in IDLE, STEP and DELIVER; 0 in LOAD and WARM.
- `prng_load` and `prng_run` are never high together.
- Reseed handling:
  - A `reseed` pulse in any state captures `seed_in` into `prng_seed` and sets `reseed_pend`.
  - IDLE with `reseed_pend`: go to LOAD. This takes priority over any `req`, which stays pending.
  - STEP or DELIVER: the current draw completes and is acked, then LOAD.
  - LOAD or WARM: restart LOAD with the new seed; the warm-up count restarts.
  - `reseed_pend` clears on entry to LOAD.
- Counter width: `$clog2(max(WARMUP_STEPS, STEPS_PER_DRAW)+1)`. It counts down to 1; no wrap.
- Illegal parameter values are rejected at elaboration.

## Timing
- Reset values while `nReset`=0:
  - state=LOAD, `prng_seed`=`DEFAULT_SEED`, `rr_ptr`=0.
  - `ack`=0, `rnd_data`=0, `prng_run`=0, `ready`=0, `busy`=1.
  - `prng_load`=1, so the generator is held loading the seed.
- After `nReset` deasserts:
  - LOAD for 1 cycle, then WARM for `WARMUP_STEPS` cycles.
  - `ready` rises `WARMUP_STEPS`+1 cycles after the first post-reset edge.
- Draw latency: the `ack` pulse appears `STEPS_PER_DRAW`+2 cycles after the IDLE cycle in which `req` was sampled.
- Throughput: one draw per `STEPS_PER_DRAW`+2 cycles.
- Requester rule: drop `req` in the cycle `ack` is seen; it may reassert on the next cycle.
- Reset mid-operation: asynchronous return to reset values. In-flight draws are lost without an ack, and pending `reseed` is discarded. Requesters holding `req` are served after the warm-up.
- `rnd_data` changes only in the cycle `ack` is asserted.

## Structure
- Package `prand_pkg`:
  - state enum `prand_state_t` (LOAD, WARM, IDLE, STEP, DELIVER);
  - `PRAND_DEFAULT_SEED` constant;
  - `PRAND_W` = 64.
- Sub-module `rr_arbiter`: inputs `req`, mask, `rr_ptr`; outputs a one-hot grant and its index. It is combinational, parameterised by `NUM_REQ`.
- The state machine, counter, seed register and output registers stay in `prand_sched`.
- The top level instantiates the LFSR generator alongside this block:
  - `prng_load` drives the generator's seed load;
  - `prng_run` drives its run enable;
  - `prng_seed` drives its seed input;
  - `prng_value` comes from its random-number output.

## Test plan
- Reset with default parameters, no `req` -> `prng_load` high for 1 cycle, `prng_run` high for exactly 64 cycles, then `ready`=1, `busy`=0, `ack`=0.
- `req`=4'b0001 in IDLE -> `prng_run` high for 8 cycles, then `ack`=4'b0001 for one cycle, 10 cycles after sampling. `rnd_data` equals the golden LFSR model after 64+8 steps from 64'h0123456789ABCDEF.
- `req`=4'b1111 held, each bit dropped on its ack and reasserted one cycle later -> ack order 0,1,2,3,0,1. Acks are 10 cycles apart and never two bits at once.
- `reseed` with `seed_in`=64'h1 during the 3rd STEP cycle of a draw for requester 2 -> requester 2 is acked with the old-seed value, then LOAD with `prng_seed`=64'h1 and 64 warm cycles. The next draw matches the golden model for seed 64'h1.
- `reseed` and `req`=4'b0100 in the same IDLE cycle -> LOAD first. `req` stays pending and is acked after the warm-up plus 10 cycles.
- `nReset` asserted during STEP -> `ack`, `rnd_data` and `prng_run` go to 0 immediately and `prng_seed` returns to the default. After release the full LOAD/WARM sequence repeats, then the held `req` is served.
